// File: rtl/rst_seq_ctrl_if.sv
// Bundle of the software-request handshake and the staged reset outputs.
// The sequencer drives it through the slave modport; the consumer side
// (board logic or a bench) uses the master modport.
`timescale 1ns/1ps
interface rst_seq_ctrl_if #(
  parameter int N_OUT = 3
);
  logic             i_sw_rst_req;
  logic [N_OUT-1:0] o_rstn;
  logic             o_rst_done;
  logic             o_sw_rst_ack;
  logic [1:0]       o_state;

  modport master (
    output i_sw_rst_req,
    input  o_rstn,
    input  o_rst_done,
    input  o_sw_rst_ack,
    input  o_state
  );

  modport slave (
    input  i_sw_rst_req,
    output o_rstn,
    output o_rst_done,
    output o_sw_rst_ack,
    output o_state
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: turns a raw asynchronous active-low board reset into
// N_OUT staged resets that assert asynchronously, deassert synchronously
// and are released lowest bit first. A software request replays the
// hold/release sequence and pulses an acknowledge when it completes.
`timescale 1ns/1ps
module rst_seq_ctrl #(
  parameter int N_SYNC    = 2,
  parameter int N_HOLD    = 4,
  parameter int N_OUT     = 3,
  parameter int STAGE_GAP = 2,
  parameter int BW_CNT    = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  rst_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int CNT_MAX = (N_HOLD > STAGE_GAP) ? N_HOLD : STAGE_GAP;
  localparam logic [BW_CNT-1:0] HOLD_LAST = BW_CNT'(N_HOLD - 1);
  localparam logic [BW_CNT-1:0] GAP_LAST  = BW_CNT'(STAGE_GAP - 1);

  // Reject configurations the counter or the sequence cannot represent.
  if (N_SYNC < 2 || N_HOLD < 1 || N_OUT < 1 || STAGE_GAP < 1 ||
      CNT_MAX >= (2 ** BW_CNT)) begin : g_param_check
    $error("rst_seq_ctrl: illegal parameters (counter would wrap or value out of range)");
  end

  logic [N_SYNC-1:0] sync_q;
  logic [N_SYNC-1:0] sync_d;
  logic              rstn_sync;
  state_t            state_q;
  logic [BW_CNT-1:0] cnt_q;
  logic [N_OUT-1:0]  rstn_q;
  logic [N_OUT-1:0]  rstn_d;
  logic              done_q;
  logic              ack_q;
  logic              pend_q;

  // The next stage to release is the lowest still-asserted bit, which keeps
  // the outputs thermometer-coded by construction.
  assign sync_d    = {sync_q[N_SYNC-2:0], 1'b1};
  assign rstn_sync = sync_q[N_SYNC-1];
  assign rstn_d    = (rstn_q << 1) | N_OUT'(1);

  // Raw reset synchronizer: clears at once, fills with ones after release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Sequencing FSM with registered resets, done, ack and state outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (state_q != ST_RESET && bus.i_sw_rst_req) begin
        // A request (new, repeated or held) always restarts the hold window.
        state_q <= ST_HOLD;
        cnt_q   <= '0;
        rstn_q  <= '0;
        done_q  <= 1'b0;
        pend_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_RESET: begin
            if (rstn_sync) begin
              state_q <= ST_HOLD;
              cnt_q   <= '0;
            end
          end
          ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              state_q <= ST_RELEASE;
              cnt_q   <= '0;
              rstn_q  <= rstn_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (&rstn_q) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
              done_q  <= 1'b1;
              ack_q   <= pend_q;
              pend_q  <= 1'b0;
            end else if (cnt_q == GAP_LAST) begin
              cnt_q  <= '0;
              rstn_q <= rstn_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_RUN: begin
            cnt_q <= '0;
          end
          default: begin
            state_q <= ST_RESET;
          end
        endcase
      end
    end
  end

  assign bus.o_rstn       = rstn_q;
  assign bus.o_rst_done   = done_q;
  assign bus.o_sw_rst_ack = ack_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl at default parameters. Expected output timelines
// are generated from the documented release formulas and queued per clock
// edge; a monitor pops and compares them one step after each rising edge.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

  localparam int NH = 4;
  localparam int G  = 2;
  localparam int NO = 3;

  typedef struct {
    int         cyc;
    logic [2:0] rstn;
    logic [1:0] st;
    logic       done;
    logic       ack;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  time  t_edge = 0;
  logic [2:0] prev_rstn = 3'b000;

  rst_seq_ctrl_if #(.N_OUT(NO)) bus ();

  rst_seq_ctrl #(
    .N_SYNC(2), .N_HOLD(NH), .N_OUT(NO), .STAGE_GAP(G), .BW_CNT(8)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  // Rising edges at 7, 17, 27, 37, 47 ... ns.
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc++;
    t_edge = $time;
  end

  function automatic void push_one(int c, logic [2:0] r, logic [1:0] s, logic d, logic a);
    exp_t e;
    e.cyc = c; e.rstn = r; e.st = s; e.done = d; e.ack = a;
    exp_q.push_back(e);
  endfunction

  // Expected timeline for a hold/release sequence entering HOLD at edge t.
  // Anything previously expected from t onward is superseded.
  function automatic void push_seq(int t, bit sw);
    int n;
    while (exp_q.size() > 0 && exp_q[$].cyc >= t) void'(exp_q.pop_back());
    for (int d = 0; d <= NH + (NO - 1) * G + 2; d++) begin
      if (d < NH) begin
        push_one(t + d, 3'b000, 2'd1, 1'b0, 1'b0);
      end else if (d <= NH + (NO - 1) * G) begin
        n = (d - NH) / G + 1;
        push_one(t + d, 3'((1 << n) - 1), 2'd2, 1'b0, 1'b0);
      end else if (d == NH + (NO - 1) * G + 1) begin
        push_one(t + d, 3'b111, 2'd3, 1'b1, sw);
      end else begin
        push_one(t + d, 3'b111, 2'd3, 1'b1, 1'b0);
      end
    end
  endfunction

  // Scoreboard: compare every expectation due at the edge just taken.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc || bus.o_rstn !== mon_e.rstn || bus.o_state !== mon_e.st ||
          bus.o_rst_done !== mon_e.done || bus.o_sw_rst_ack !== mon_e.ack) begin
        n_fail++;
        $display("FAIL seq edge %0d (now %0d): got rstn=%b state=%0d done=%b ack=%b, want rstn=%b state=%0d done=%b ack=%b",
                 mon_e.cyc, cyc, bus.o_rstn, bus.o_state, bus.o_rst_done, bus.o_sw_rst_ack,
                 mon_e.rstn, mon_e.st, mon_e.done, mon_e.ack);
      end
    end
  end

  // Any staged reset release must coincide with a rising clock edge.
  always @(bus.o_rstn) begin
    if ((|(bus.o_rstn & ~prev_rstn)) === 1'b1) begin
      n_checks++;
      if ($time != t_edge) begin
        n_fail++;
        $display("FAIL release_on_edge: rstn %b->%b at %0t, last edge %0t", prev_rstn, bus.o_rstn, $time, t_edge);
      end
    end
    prev_rstn = bus.o_rstn;
  end

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (exp_q.size() == 0) ok = 1'b1;
  endtask

  task automatic test_reset();
    #8;
    n_checks++;
    if (bus.o_rstn !== 3'b000) begin n_fail++; $display("FAIL reset_rstn: got %b want 000", bus.o_rstn); end
    n_checks++;
    if (bus.o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.o_state); end
    n_checks++;
    if (bus.o_rst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_rst_done); end
    n_checks++;
    if (bus.o_sw_rst_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.o_sw_rst_ack); end
  endtask

  task automatic test_powerup();
    int e0;
    bit ok;
    #32;
    rstn = 1'b1;
    e0 = cyc + 1;
    push_one(e0,     3'b000, 2'd0, 1'b0, 1'b0);
    push_one(e0 + 1, 3'b000, 2'd0, 1'b0, 1'b0);
    push_seq(e0 + 2, 1'b0);
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL powerup_timeout: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_sw_req();
    bit ok;
    bus.i_sw_rst_req = 1'b1;
    push_seq(cyc + 1, 1'b1);
    @(posedge clk);
    #2;
    bus.i_sw_rst_req = 1'b0;
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sw_req_timeout: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.i_sw_rst_req = 1'b1;
    push_seq(cyc + 1, 1'b1);
    @(posedge clk);
    #2;
    bus.i_sw_rst_req = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    n_checks++;
    if (bus.o_rstn !== 3'b011) begin n_fail++; $display("FAIL restart_pre: got %b want 011", bus.o_rstn); end
    bus.i_sw_rst_req = 1'b1;
    push_seq(cyc + 1, 1'b1);
    @(posedge clk);
    #2;
    bus.i_sw_rst_req = 1'b0;
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL restart_timeout: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_raw_mid();
    int e0;
    bit ok;
    bus.i_sw_rst_req = 1'b1;
    push_seq(cyc + 1, 1'b1);
    @(posedge clk);
    #2;
    bus.i_sw_rst_req = 1'b0;
    repeat (6) @(posedge clk);
    #5;
    n_checks++;
    if (bus.o_rstn !== 3'b011) begin n_fail++; $display("FAIL raw_pre: got %b want 011", bus.o_rstn); end
    exp_q.delete();
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.o_rstn !== 3'b000) begin n_fail++; $display("FAIL raw_async_rstn: got %b want 000", bus.o_rstn); end
    n_checks++;
    if (bus.o_state !== 2'd0) begin n_fail++; $display("FAIL raw_async_state: got %0d want 0", bus.o_state); end
    n_checks++;
    if (bus.o_rst_done !== 1'b0) begin n_fail++; $display("FAIL raw_async_done: got %b want 0", bus.o_rst_done); end
    #2;
    rstn = 1'b1;
    e0 = cyc + 1;
    push_one(e0,     3'b000, 2'd0, 1'b0, 1'b0);
    push_one(e0 + 1, 3'b000, 2'd0, 1'b0, 1'b0);
    push_seq(e0 + 2, 1'b0);
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL raw_mid_timeout: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_held();
    bit ok;
    bus.i_sw_rst_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_seq(cyc + 1, 1'b1);
      @(posedge clk);
      #2;
      n_checks++;
      if (bus.o_state !== 2'd1 || bus.o_rstn !== 3'b000) begin
        n_fail++;
        $display("FAIL held_%0d: got state=%0d rstn=%b want state=1 rstn=000", i, bus.o_state, bus.o_rstn);
      end
    end
    bus.i_sw_rst_req = 1'b0;
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL held_timeout: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic [2:0] th;
    exp_q.delete();
    for (int it = 0; it < 100; it++) begin
      @(posedge clk);
      #($urandom_range(1, 9));
      rstn = 1'b0;
      #1;
      n_checks++;
      if (bus.o_rstn !== 3'b000) begin n_fail++; $display("FAIL rand_assert_%0d: got %b want 000", it, bus.o_rstn); end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #($urandom_range(0, 10));
      bus.i_sw_rst_req = 1'($urandom_range(0, 1));
      rstn = 1'b1;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk);
        #2;
        bus.i_sw_rst_req = ($urandom_range(0, 7) == 0);
        th = bus.o_rstn;
        n_checks++;
        if ((th & (th + 3'd1)) !== 3'd0) begin
          n_fail++;
          $display("FAIL rand_thermo_%0d: got %b want thermometer code", it, th);
        end
      end
    end
    bus.i_sw_rst_req = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.i_sw_rst_req = 1'b0;
    test_reset();
    test_powerup();
    test_sw_req();
    test_back_to_back();
    test_raw_mid();
    test_held();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
